dark_pixel_cnt: RTL
===================

DARK_PIXEL_CNT -- requirements
Module: dark_pixel_cnt

Interface
REQ-001 SHALL have parameter DATA_W, default 12, pixel gray width.
REQ-002 SHALL have parameter DARK_TH, default 12'd256, dark threshold; pixel is dark when iGray < DARK_TH.
REQ-003 SHALL have port iCLK  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port iRST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port iFVAL  input  1  frame valid from camera capture; high for the whole active frame.
REQ-006 SHALL have port iDVAL  input  1  pixel valid qualifier for iGray.
REQ-007 SHALL have port iGray  input  DATA_W  pixel gray level, sampled only when iDVAL=1.
REQ-008 SHALL have port iEnable  input  1  counting enable; sampled at frame start only.
REQ-009 SHALL have port oDarkCounter  output  16  dark-pixel count of the last completed frame; feeds the alarm/sound selector.
REQ-010 SHALL have port oCountValid  output  1  one-cycle pulse when oDarkCounter updates.
REQ-011 SHALL have port oSaturated  output  1  last completed frame's count clipped at 16'hFFFF.
REQ-012 SHALL have port oFrameCnt  output  8  number of completed counted frames, wraps 8'hFF -> 8'h00.

Function
REQ-013 SHALL implement FSM states SYNC, IDLE, COUNT, LATCH.
REQ-014 SYNC SHALL be entered from reset; leave to IDLE on the first cycle iFVAL=0, so a frame already in progress at reset is never counted.
REQ-015 IDLE SHALL detect the iFVAL rising edge (registered iFVAL 0 -> current 1); if iEnable=1 that cycle, go to COUNT and clear the accumulator; else stay IDLE, ignore the frame.
REQ-016 The rising-edge cycle SHALL itself be counted if iDVAL=1 and iGray < DARK_TH (accumulator loads 1 instead of 0).
REQ-017 COUNT SHALL increment the 16-bit accumulator by 1 each cycle iDVAL=1 and iGray < DARK_TH; pixels with iGray >= DARK_TH or iDVAL=0 not counted.
REQ-018 Accumulator SHALL saturate at 16'hFFFF, never wrap; a sticky sat flag sets when an increment is attempted at 16'hFFFF.
REQ-019 COUNT SHALL go to LATCH on the cycle iFVAL samples 0; a pixel with iDVAL=1 in that cycle SHALL NOT be counted.
REQ-020 LATCH (one cycle) SHALL load oDarkCounter <= accumulator, oSaturated <= sat flag, oFrameCnt <= oFrameCnt+1, pulse oCountValid=1, then go to IDLE.
REQ-021 Latency: oCountValid high exactly 2 cycles after the first cycle iFVAL samples 0.
REQ-022 oDarkCounter, oSaturated SHALL hold their values between LATCH events; iEnable changes mid-frame SHALL have no effect.
REQ-023 iFVAL rising in the LATCH cycle SHALL be missed; the next frame is skipped (IDLE waits for a fresh rising edge).
REQ-024 oCountValid SHALL be 0 in all states other than LATCH.

Reset
REQ-025 On iRST=0, asynchronously: state SYNC, accumulator 0, sat flag 0, oDarkCounter 16'h0000, oCountValid 0, oSaturated 0, oFrameCnt 8'h00, registered iFVAL 0.
REQ-026 Reset asserted mid-frame SHALL discard the partial count; after release the block re-enters SYNC and counts nothing until iFVAL has been low.

Verification
REQ-027 Frame of 1000 valid pixels, 300 with iGray=12'd100, 700 with iGray=12'd256, iEnable=1 -> oDarkCounter=16'd300, oCountValid single pulse 2 cycles after iFVAL falls, oFrameCnt=1, oSaturated=0.
REQ-028 Frame of 70000 valid pixels all iGray=0 -> oDarkCounter=16'hFFFF, oSaturated=1; following frame with 10 dark pixels -> oDarkCounter=16'd10, oSaturated=0.
REQ-029 Release reset while iFVAL=1 with dark pixels present -> no oCountValid for that frame; next full frame counted correctly.
REQ-030 iEnable=0 at frame start, toggled to 1 mid-frame -> no oCountValid, oDarkCounter unchanged; iEnable=1 at next start -> counted.
REQ-031 Dark pixel with iDVAL=0, and dark pixel coincident with iFVAL falling -> neither counted; iGray=DARK_TH-1 counted, iGray=DARK_TH not.
REQ-032 256 consecutive counted frames -> oFrameCnt wraps to 8'h00, one oCountValid per frame.

Source files
------------

// File: rtl/dark_pixel_cnt.sv
// Counts dark pixels (gray below a threshold) over each camera frame and
// publishes the per-frame count, a saturation flag and a frame counter.
module dark_pixel_cnt #(
  parameter int unsigned       DATA_W  = 12,
  parameter logic [DATA_W-1:0] DARK_TH = DATA_W'(256)
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iFVAL,
  input  logic              iDVAL,
  input  logic [DATA_W-1:0] iGray,
  input  logic              iEnable,
  output logic [15:0]       oDarkCounter,
  output logic              oCountValid,
  output logic              oSaturated,
  output logic [7:0]        oFrameCnt
);

  typedef enum logic [1:0] {StSync, StIdle, StCount, StLatch} state_e;

  state_e      state_q, state_d;
  logic        fval_q, fval_d;
  logic [15:0] acc_q, acc_d;
  logic        sat_q, sat_d;
  logic [15:0] dark_cnt_q, dark_cnt_d;
  logic        cnt_valid_q, cnt_valid_d;
  logic        out_sat_q, out_sat_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;

  logic dark_px;
  logic fval_rise;

  assign dark_px   = iDVAL && (iGray < DARK_TH);
  assign fval_rise = iFVAL && !fval_q;

  always_comb begin
    state_d     = state_q;
    fval_d      = iFVAL;
    acc_d       = acc_q;
    sat_d       = sat_q;
    dark_cnt_d  = dark_cnt_q;
    cnt_valid_d = 1'b0;
    out_sat_d   = out_sat_q;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      // Wait for a frame gap so a frame already running at reset is never counted.
      StSync: begin
        if (!iFVAL) state_d = StIdle;
      end
      StIdle: begin
        // iEnable is only honoured on the frame's first cycle, which is itself counted.
        if (fval_rise && iEnable) begin
          state_d = StCount;
          acc_d   = dark_px ? 16'd1 : 16'd0;
          sat_d   = 1'b0;
        end
      end
      StCount: begin
        if (!iFVAL) begin
          state_d = StLatch;
        end else if (dark_px) begin
          if (acc_q == 16'hFFFF) sat_d = 1'b1;
          else                   acc_d = acc_q + 16'd1;
        end
      end
      StLatch: begin
        state_d     = StIdle;
        dark_cnt_d  = acc_q;
        out_sat_d   = sat_q;
        frame_cnt_d = frame_cnt_q + 8'd1;
        cnt_valid_d = 1'b1;
      end
      default: state_d = StSync;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q     <= StSync;
      fval_q      <= 1'b0;
      acc_q       <= 16'h0000;
      sat_q       <= 1'b0;
      dark_cnt_q  <= 16'h0000;
      cnt_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
      frame_cnt_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      fval_q      <= fval_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      dark_cnt_q  <= dark_cnt_d;
      cnt_valid_q <= cnt_valid_d;
      out_sat_q   <= out_sat_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign oDarkCounter = dark_cnt_q;
  assign oCountValid  = cnt_valid_q;
  assign oSaturated   = out_sat_q;
  assign oFrameCnt    = frame_cnt_q;

endmodule
